// File: rtl/mips_multicycle_controller_if.sv
// Control bundle between the multicycle controller and the shared-memory datapath.
// The controller is the master: it consumes IR fields and the ALU zero flag and
// drives every datapath select and enable.
interface mips_multicycle_controller_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       iord;
  logic       irwrite;
  logic       memwrite;
  logic       memtoreg;
  logic       regdst;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic       pcen;
  logic       illegal;

  modport master (
    input  opcode, funct, zero,
    output iord, irwrite, memwrite, memtoreg, regdst, regwrite,
           alusrca, alusrcb, pcsrc, alucontrol, pcen, illegal
  );

  modport slave (
    output opcode, funct, zero,
    input  iord, irwrite, memwrite, memtoreg, regdst, regwrite,
           alusrca, alusrcb, pcsrc, alucontrol, pcen, illegal
  );
endinterface

// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS control unit: Moore FSM with registered control outputs plus
// the R-type ALU decoder. Outputs are computed for the state being entered and
// registered on the same edge, so they are glitch-free for the whole state.
// pcen (needs zero in BEQ) and illegal (needs the IR opcode in DECODE) are the
// only combinational outputs.
module mips_multicycle_controller #(
  parameter bit ENABLE_ADDI = 1'b1,
  parameter bit ENABLE_J    = 1'b1
) (
  input logic clk,
  input logic reset,
  mips_multicycle_controller_if.master ctl
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXEC, ALUWB, BEQ, ADDIEX, ADDIWB, JMP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_t     state_r, next_s;
  // Cleared by reset; the first edge after release spends itself entering FETCH.
  logic       started_r;

  logic       iord_r, irwrite_r, memwrite_r, memtoreg_r, regdst_r, regwrite_r;
  logic       alusrca_r, pcwrite_r, branch_r;
  logic [1:0] alusrcb_r, pcsrc_r;
  logic [2:0] alucontrol_r;

  logic       iord_s, irwrite_s, memwrite_s, memtoreg_s, regdst_s, regwrite_s;
  logic       alusrca_s, pcwrite_s, branch_s;
  logic [1:0] alusrcb_s, pcsrc_s;
  logic [2:0] alucontrol_s;

  // Opcodes the controller knows how to sequence under the current parameters.
  function automatic logic is_legal(input logic [5:0] op);
    logic ok;
    case (op)
      OP_RTYPE, OP_BEQ, OP_LW, OP_SW: ok = 1'b1;
      OP_ADDI:                        ok = ENABLE_ADDI;
      OP_J:                           ok = ENABLE_J;
      default:                        ok = 1'b0;
    endcase
    return ok;
  endfunction

  // R-type funct to ALU operation; unknown functs quietly default to add.
  function automatic logic [2:0] alu_decode(input logic [5:0] fn);
    logic [2:0] op;
    case (fn)
      6'b100000: op = 3'b010;
      6'b100010: op = 3'b110;
      6'b100100: op = 3'b000;
      6'b100101: op = 3'b001;
      6'b101010: op = 3'b111;
      default:   op = 3'b010;
    endcase
    return op;
  endfunction

  // Next-state selection; IR fields are only consulted in DECODE and MEMADR.
  always_comb begin
    next_s = FETCH;
    if (!started_r) begin
      next_s = FETCH;
    end else begin
      case (state_r)
        FETCH:  next_s = DECODE;
        DECODE: begin
          if (!is_legal(ctl.opcode)) begin
            next_s = FETCH;
          end else begin
            case (ctl.opcode)
              OP_LW, OP_SW: next_s = MEMADR;
              OP_RTYPE:     next_s = EXEC;
              OP_BEQ:       next_s = BEQ;
              OP_ADDI:      next_s = ADDIEX;
              OP_J:         next_s = JMP;
              default:      next_s = FETCH;
            endcase
          end
        end
        MEMADR: begin
          if (ctl.opcode == OP_LW) begin
            next_s = MEMRD;
          end else if (ctl.opcode == OP_SW) begin
            next_s = MEMWR;
          end else begin
            next_s = FETCH;
          end
        end
        MEMRD:   next_s = MEMWB;
        EXEC:    next_s = ALUWB;
        ADDIEX:  next_s = ADDIWB;
        default: next_s = FETCH;
      endcase
    end
  end

  // Control values for the state about to be entered (registered below).
  always_comb begin
    iord_s       = 1'b0;
    irwrite_s    = 1'b0;
    memwrite_s   = 1'b0;
    memtoreg_s   = 1'b0;
    regdst_s     = 1'b0;
    regwrite_s   = 1'b0;
    alusrca_s    = 1'b0;
    alusrcb_s    = 2'b00;
    pcsrc_s      = 2'b00;
    alucontrol_s = 3'b000;
    pcwrite_s    = 1'b0;
    branch_s     = 1'b0;
    case (next_s)
      FETCH:  begin irwrite_s = 1'b1; alusrcb_s = 2'b01; alucontrol_s = 3'b010; pcwrite_s = 1'b1; end
      DECODE: begin alusrcb_s = 2'b11; alucontrol_s = 3'b010; end
      MEMADR: begin alusrca_s = 1'b1; alusrcb_s = 2'b10; alucontrol_s = 3'b010; end
      MEMRD:  begin iord_s = 1'b1; end
      MEMWB:  begin memtoreg_s = 1'b1; regwrite_s = 1'b1; end
      MEMWR:  begin iord_s = 1'b1; memwrite_s = 1'b1; end
      EXEC:   begin alusrca_s = 1'b1; alucontrol_s = alu_decode(ctl.funct); end
      ALUWB:  begin regdst_s = 1'b1; regwrite_s = 1'b1; end
      BEQ:    begin alusrca_s = 1'b1; alucontrol_s = 3'b110; pcsrc_s = 2'b01; branch_s = 1'b1; end
      ADDIEX: begin alusrca_s = 1'b1; alusrcb_s = 2'b10; alucontrol_s = 3'b010; end
      ADDIWB: begin regwrite_s = 1'b1; end
      JMP:    begin pcsrc_s = 2'b10; pcwrite_s = 1'b1; end
      default: begin end
    endcase
  end

  // State and output registers; reset parks in FETCH with every write enable off.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= FETCH;
      started_r    <= 1'b0;
      iord_r       <= 1'b0;
      irwrite_r    <= 1'b0;
      memwrite_r   <= 1'b0;
      memtoreg_r   <= 1'b0;
      regdst_r     <= 1'b0;
      regwrite_r   <= 1'b0;
      alusrca_r    <= 1'b0;
      alusrcb_r    <= 2'b01;
      pcsrc_r      <= 2'b00;
      alucontrol_r <= 3'b010;
      pcwrite_r    <= 1'b0;
      branch_r     <= 1'b0;
    end else begin
      state_r      <= next_s;
      started_r    <= 1'b1;
      iord_r       <= iord_s;
      irwrite_r    <= irwrite_s;
      memwrite_r   <= memwrite_s;
      memtoreg_r   <= memtoreg_s;
      regdst_r     <= regdst_s;
      regwrite_r   <= regwrite_s;
      alusrca_r    <= alusrca_s;
      alusrcb_r    <= alusrcb_s;
      pcsrc_r      <= pcsrc_s;
      alucontrol_r <= alucontrol_s;
      pcwrite_r    <= pcwrite_s;
      branch_r     <= branch_s;
    end
  end

  assign ctl.iord       = iord_r;
  assign ctl.irwrite    = irwrite_r;
  assign ctl.memwrite   = memwrite_r;
  assign ctl.memtoreg   = memtoreg_r;
  assign ctl.regdst     = regdst_r;
  assign ctl.regwrite   = regwrite_r;
  assign ctl.alusrca    = alusrca_r;
  assign ctl.alusrcb    = alusrcb_r;
  assign ctl.pcsrc      = pcsrc_r;
  assign ctl.alucontrol = alucontrol_r;
  // zero is used live so a taken branch loads the PC in the BEQ cycle itself.
  assign ctl.pcen       = pcwrite_r | (branch_r & ctl.zero);
  assign ctl.illegal    = (state_r == DECODE) && !is_legal(ctl.opcode);

endmodule
